// File: rtl/ieee754_adder.sv
// ieee754_adder
//   Multi-cycle IEEE-754 binary32 adder. A start pulse latches both operands;
//   the operation then walks ALIGN -> ADD -> NORM -> ROUND, one state per cycle.
//   The result is registered on the ROUND->IDLE edge together with a one-cycle
//   valid pulse. Subnormal inputs are flushed to signed zero; rounding is
//   round-to-nearest, ties-to-even.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous reset, active low
//   input1  operand A (binary32)
//   input2  operand B (binary32)
//   strt    start request, ignored while busy
//   valid   one-cycle pulse when out carries a new result
//   busy    high while an operation is in flight
//   out     A+B (binary32), held until the next result
module ieee754_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic        strt,
  output logic        valid,
  output logic        busy,
  output logic [31:0] out
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND
  } state_t;

  state_t state, state_nx;

  // Leading-zero count of a 27-bit significand, resolved in a single cycle.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Round-to-nearest-even on {mant[23:0], g, r, s}, then saturate the
  // exponent: overflow goes to signed infinity, underflow to signed zero.
  function automatic logic [31:0] round_pack(input logic              sign,
                                             input logic signed [9:0] exp_in,
                                             input logic [26:0]       sig);
    logic [24:0]       mant;
    logic              up;
    logic signed [9:0] e;
    logic [22:0]       frac;
    up   = sig[2] & (sig[1] | sig[0] | sig[3]);
    mant = {1'b0, sig[26:3]} + {24'd0, up};
    e    = exp_in;
    // A carry out of rounding renormalises by one place.
    if (mant[24]) begin
      e    = e + 10'sd1;
      frac = mant[23:1];
    end else begin
      frac = mant[22:0];
    end
    if (exp_in <= 10'sd0)      return {sign, 31'd0};
    else if (e >= 10'sd255)    return {sign, 8'hFF, 23'd0};
    else                       return {sign, e[7:0], frac};
  endfunction

  // Latched operands
  logic [31:0] a_p0, b_p0;

  // ALIGN results
  logic        sign_p1, sub_p1, spec_p1;
  logic [31:0] spec_val_p1;
  logic [7:0]  exp_p1;
  logic [26:0] sig_l_p1, sig_s_p1;

  // ADD results
  logic        sign_p2, spec_p2;
  logic [31:0] spec_val_p2;
  logic [7:0]  exp_p2;
  logic [27:0] sum_p2;

  // NORM results
  logic              sign_p3, spec_p3;
  logic [31:0]       spec_val_p3;
  logic signed [9:0] exp_p3;
  logic [26:0]       sig_p3;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (strt) state_nx = S_ALIGN;
      S_ALIGN: state_nx = S_ADD;
      S_ADD:   state_nx = S_NORM;
      S_NORM:  state_nx = S_ROUND;
      S_ROUND: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------- ALIGN
  logic [7:0]  ea, eb, el, es, dexp;
  logic [23:0] ma, mb, ml, ms;
  logic        swap, nan_a, nan_b, inf_a, inf_b;
  logic [26:0] ext_s, lost_s;
  logic        al_sign, al_sub, al_spec;
  logic [31:0] al_spec_val;
  logic [26:0] al_sig_l, al_sig_s;

  always_comb begin
    ea    = a_p0[30:23];
    eb    = b_p0[30:23];
    // Exponent 0 flushes to zero: no hidden bit and the fraction is dropped.
    ma    = (ea != 8'd0) ? {1'b1, a_p0[22:0]} : 24'd0;
    mb    = (eb != 8'd0) ? {1'b1, b_p0[22:0]} : 24'd0;
    swap  = {eb, mb[22:0]} > {ea, ma[22:0]};
    el    = swap ? eb : ea;
    es    = swap ? ea : eb;
    ml    = swap ? mb : ma;
    ms    = swap ? ma : mb;
    dexp  = el - es;
    ext_s = {ms, 3'b000};
    lost_s = 27'd0;
    if (dexp >= 8'd27) begin
      al_sig_s = {26'd0, |ms};
    end else begin
      lost_s   = ext_s & ((27'd1 << dexp[4:0]) - 27'd1);
      al_sig_s = (ext_s >> dexp[4:0]) | {26'd0, |lost_s};
    end
    al_sig_l = {ml, 3'b000};
    al_sign  = swap ? b_p0[31] : a_p0[31];
    al_sub   = a_p0[31] ^ b_p0[31];

    nan_a = (ea == 8'hFF) && (a_p0[22:0] != 23'd0);
    nan_b = (eb == 8'hFF) && (b_p0[22:0] != 23'd0);
    inf_a = (ea == 8'hFF) && (a_p0[22:0] == 23'd0);
    inf_b = (eb == 8'hFF) && (b_p0[22:0] == 23'd0);

    al_spec     = 1'b1;
    al_spec_val = 32'd0;
    if (nan_a || nan_b)                 al_spec_val = QNAN;
    else if (inf_a && inf_b && al_sub)  al_spec_val = QNAN;
    else if (inf_a)                     al_spec_val = a_p0;
    else if (inf_b)                     al_spec_val = b_p0;
    // Both zero: the result is -0 only when both operands are -0.
    else if (ea == 8'd0 && eb == 8'd0)  al_spec_val = {a_p0[31] & b_p0[31], 31'd0};
    else                                al_spec = 1'b0;
  end

  // ---------------------------------------------------------------- ADD
  logic [27:0] add_sum;

  always_comb begin
    // Operand L is never smaller than the aligned S, so the difference is >= 0.
    if (sub_p1) add_sum = {1'b0, sig_l_p1} - {1'b0, sig_s_p1};
    else        add_sum = {1'b0, sig_l_p1} + {1'b0, sig_s_p1};
  end

  // ---------------------------------------------------------------- NORM
  logic [4:0]        lz;
  logic [26:0]       nm_sig;
  logic signed [9:0] nm_exp;
  logic              nm_spec;
  logic [31:0]       nm_spec_val;

  always_comb begin
    lz          = lzc27(sum_p2[26:0]);
    nm_spec     = spec_p2;
    nm_spec_val = spec_val_p2;
    // Exact cancellation always yields +0 regardless of operand signs.
    if (!spec_p2 && sum_p2 == 28'd0) begin
      nm_spec     = 1'b1;
      nm_spec_val = 32'd0;
    end
    if (sum_p2[27]) begin
      nm_sig = {sum_p2[27:2], sum_p2[1] | sum_p2[0]};
      nm_exp = $signed({2'b00, exp_p2}) + 10'sd1;
    end else begin
      // Large left shifts only follow near-total cancellation, where the
      // low-order bits are exact, so shifting zeros in is safe.
      nm_sig = sum_p2[26:0] << lz;
      nm_exp = $signed({2'b00, exp_p2}) - $signed({5'd0, lz});
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_p0        <= 32'd0;
      b_p0        <= 32'd0;
      sign_p1     <= 1'b0;
      sub_p1      <= 1'b0;
      spec_p1     <= 1'b0;
      spec_val_p1 <= 32'd0;
      exp_p1      <= 8'd0;
      sig_l_p1    <= 27'd0;
      sig_s_p1    <= 27'd0;
      sign_p2     <= 1'b0;
      spec_p2     <= 1'b0;
      spec_val_p2 <= 32'd0;
      exp_p2      <= 8'd0;
      sum_p2      <= 28'd0;
      sign_p3     <= 1'b0;
      spec_p3     <= 1'b0;
      spec_val_p3 <= 32'd0;
      exp_p3      <= 10'sd0;
      sig_p3      <= 27'd0;
      out         <= 32'd0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (strt) begin
            a_p0 <= input1;
            b_p0 <= input2;
          end
        end
        S_ALIGN: begin
          sign_p1     <= al_sign;
          sub_p1      <= al_sub;
          spec_p1     <= al_spec;
          spec_val_p1 <= al_spec_val;
          exp_p1      <= el;
          sig_l_p1    <= al_sig_l;
          sig_s_p1    <= al_sig_s;
        end
        S_ADD: begin
          sign_p2     <= sign_p1;
          spec_p2     <= spec_p1;
          spec_val_p2 <= spec_val_p1;
          exp_p2      <= exp_p1;
          sum_p2      <= add_sum;
        end
        S_NORM: begin
          sign_p3     <= sign_p2;
          spec_p3     <= nm_spec;
          spec_val_p3 <= nm_spec_val;
          exp_p3      <= nm_exp;
          sig_p3      <= nm_sig;
        end
        S_ROUND: begin
          out   <= spec_p3 ? spec_val_p3 : round_pack(sign_p3, exp_p3, sig_p3);
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ieee754_adder.sv
module tb_ieee754_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input1, input2;
  logic        strt;
  logic        valid, busy;
  logic [31:0] out;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ieee754_adder dut (
    .clk   (clk),
    .rst   (rst),
    .input1(input1),
    .input2(input2),
    .strt  (strt),
    .valid (valid),
    .busy  (busy),
    .out   (out)
  );

  // Drive a one-cycle start at the current negedge; expected result goes to
  // the scoreboard. Returns at the negedge right after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    input1 = a;
    input2 = b;
    strt   = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    strt = 1'b0;
  endtask

  // Bounded wait for valid, counting negedges since the accepting edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    strt   = 1'b0;
    input1 = 32'd0;
    input2 = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (out !== 32'd0) begin failures++; $display("FAIL reset_out got=%h want=00000000", out); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mixed_sign();
    logic [31:0] e;
    start_op(32'hC44D5D0E, 32'h44813A7F, 32'h43545FC0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mixed_busy edge%0d got=%b want=1", k + 1, busy); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mixed_early_valid edge%0d got=%b want=0", k + 1, valid); end
      @(negedge clk);
    end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL mixed_valid got=%b want=1", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mixed_busy_drop got=%b want=0", busy); end
    e = exp_q.pop_front();
    checks++; if (out !== e) begin failures++; $display("FAIL mixed_out got=%h want=%h", out, e); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mixed_valid_pulse got=%b want=0", valid); end
    checks++; if (out !== e) begin failures++; $display("FAIL mixed_out_hold got=%h want=%h", out, e); end
  endtask

  task automatic test_cancellation();
    logic [31:0] ta[2] = '{32'h44454000, 32'hC423C000};
    logic [31:0] tb[2] = '{32'hC423C000, 32'h44454000};
    int lat;
    logic [31:0] e;
    for (int i = 0; i < 2; i++) begin
      start_op(ta[i], tb[i], 32'h43060000);
      wait_valid(lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL cancel%0d_latency got=%0d want=4", i, lat); end
      e = exp_q.pop_front();
      checks++; if (out !== e) begin failures++; $display("FAIL cancel%0d_out got=%h want=%h", i, out, e); end
    end
  endtask

  task automatic test_carry();
    int lat;
    logic [31:0] e;
    start_op(32'h440DF8F6, 32'h442C8000, 32'h449D3C7B);
    wait_valid(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL carry_latency got=%0d want=4", lat); end
    e = exp_q.pop_front();
    checks++; if (out !== e) begin failures++; $display("FAIL carry_out got=%h want=%h", out, e); end
  endtask

  task automatic test_rounding();
    // tie-to-even, above-half, sticky-only (far), far subtraction rounding back up
    logic [31:0] ta[4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] tb[4] = '{32'h33800000, 32'h33C00000, 32'h00800000, 32'hB0800000};
    logic [31:0] te[4] = '{32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h3F800000};
    int lat;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i], te[i]);
      wait_valid(lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL round%0d_latency got=%0d want=4", i, lat); end
      e = exp_q.pop_front();
      checks++; if (out !== e) begin failures++; $display("FAIL round%0d_out got=%h want=%h", i, out, e); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] ta[10] = '{32'h7F800000, 32'h40400000, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001,
                            32'h80000000, 32'h00000000, 32'h00000001, 32'h00800001, 32'h80800001};
    logic [31:0] tb[10] = '{32'hFF800000, 32'hC0400000, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000,
                            32'h80000000, 32'h80000000, 32'h3F800000, 32'h80800000, 32'h00800000};
    logic [31:0] te[10] = '{32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h7F800000, 32'h7FC00000,
                            32'h80000000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h80000000};
    int lat;
    logic [31:0] e;
    for (int i = 0; i < 10; i++) begin
      start_op(ta[i], tb[i], te[i]);
      wait_valid(lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL special%0d_latency got=%0d want=4", i, lat); end
      e = exp_q.pop_front();
      checks++; if (out !== e) begin failures++; $display("FAIL special%0d_out got=%h want=%h", i, out, e); end
    end
  endtask

  task automatic test_strt_held();
    int pulses = 0;
    logic [31:0] seen = 32'd0;
    logic [31:0] e;
    input1 = 32'h40400000;
    input2 = 32'h40000000;
    strt   = 1'b1;
    exp_q.push_back(32'h40A00000);
    @(negedge clk);
    // Operands change while busy; the latched ones must be used.
    input1 = 32'h3F800000;
    input2 = 32'h3F800000;
    @(negedge clk);
    @(negedge clk);
    strt = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (valid) begin
        pulses++;
        seen = out;
      end
      @(negedge clk);
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL held_pulses got=%0d want=1", pulses); end
    e = exp_q.pop_front();
    checks++; if (seen !== e) begin failures++; $display("FAIL held_out got=%h want=%h", seen, e); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_busy got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] e;
    start_op(32'h3F800000, 32'h40000000, 32'h40400000);
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++; if (out !== e) begin failures++; $display("FAIL b2b_first_out got=%h want=%h", out, e); end
    // Start again right on the cycle the result appears (accepted at edge 5).
    start_op(32'hC0A00000, 32'h3F800000, 32'hC0800000);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b want=1", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%b want=0", valid); end
    wait_valid(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency got=%0d want=4", lat); end
    e = exp_q.pop_front();
    checks++; if (out !== e) begin failures++; $display("FAIL b2b_second_out got=%h want=%h", out, e); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    int lat;
    logic [31:0] e;
    input1 = 32'h44454000;
    input2 = 32'h44454000;
    strt   = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (out !== 32'd0) begin failures++; $display("FAIL abort_out got=%h want=00000000", out); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b want=0", valid); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (valid) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_pulses got=%0d want=0", pulses); end
    checks++; if (out !== 32'd0) begin failures++; $display("FAIL abort_out_after got=%h want=00000000", out); end
    // Block must accept work normally after the abort.
    start_op(32'h40000000, 32'h40000000, 32'h40800000);
    wait_valid(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL recover_latency got=%0d want=4", lat); end
    e = exp_q.pop_front();
    checks++; if (out !== e) begin failures++; $display("FAIL recover_out got=%h want=%h", out, e); end
  endtask

  initial begin
    test_reset();
    test_mixed_sign();
    test_cancellation();
    test_carry();
    test_rounding();
    test_specials();
    test_strt_held();
    test_back_to_back();
    test_reset_abort();
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/ieee754_adder.md
Name: ieee754_adder

Overview:
- Sequential IEEE-754 single-precision (binary32) floating-point adder for the ALU datapath.
- Operands and a one-cycle start pulse go in; the block unpacks, aligns, adds or subtracts, normalises, rounds and packs over a fixed number of cycles.
- It returns the result with a one-cycle valid pulse and a busy flag.

Parameters:
- None. Format is fixed binary32: 1 sign, 8 exponent (bias 127), 23 fraction bits.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- input1  input  32  operand A, binary32.
- input2  input  32  operand B, binary32.
- strt  input  1  start request, sampled on the rising edge of clk.
- valid  output  1  one-cycle pulse when out holds a new result.
- busy  output  1  high while an operation is in flight.
- out  output  32  result A+B, binary32; held until the next result.

Behaviour:
- Reset (rst=0, asynchronous):
  - out=0, valid=0, busy=0.
  - FSM goes to IDLE; internal registers are cleared.
  - Reset mid-operation aborts the operation; no valid is produced.
- FSM states: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE.
- IDLE:
  - On a clk edge with strt=1, latch input1/input2, assert busy, go to ALIGN.
  - strt=0 stays in IDLE.
- ALIGN:
  - Unpack operands; prepend the hidden bit when the exponent is nonzero.
  - Swap so the larger magnitude is operand L.
  - Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits.
  - A difference of 27 or more leaves only sticky.
- ADD:
  - Equal signs: add significands.
  - Differing signs: subtract smaller from larger magnitude.
  - Result sign = sign of L.
- NORM:
  - Carry out: shift right 1, exponent +1, sticky accumulates the shifted-out bit.
  - Cancellation: shift left by the leading-zero count and decrement the exponent; single-cycle LZC, no iteration.
- ROUND:
  - Round to nearest, ties to even, using guard/round/sticky.
  - A mantissa overflow from rounding renormalises and increments the exponent.
  - Pack the result into out.
  - Assert valid for exactly this one cycle, deassert busy, return to IDLE.
- Timing:
  - strt sampled at edge 0; out and valid updated at edge 4.
  - busy is high from edge 1 through edge 4 inclusive and low from edge 5.
  - A new strt is accepted at edge 5 or later.
- strt while busy is ignored; latched operands are unaffected by later input changes.
- Special cases (resolved in ALIGN, result carried to ROUND with the same latency):
  - Either operand NaN -> 0x7FC00000.
  - +inf + -inf -> 0x7FC00000.
  - inf + finite -> that inf.
  - Exponent 0 inputs (zero or subnormal) are treated as signed zero; flush to zero.
  - Exact cancellation (x + -x) -> +0 (0x00000000).
  - (+0)+(+0) -> +0; (-0)+(-0) -> -0; (+0)+(-0) -> +0.
  - Exponent overflow after rounding -> signed infinity (exp 0xFF, fraction 0).
  - Exponent underflow (<=0) after normalisation -> signed zero.

Test Plan:
- Mixed-sign, smaller magnitude negative: reset, release rst, strt pulse with input1=0xC44D5D0E (-821.454), input2=0x44813A7F (1033.828) -> valid at edge 4 with out=0x43545FC0 (212.374); busy high edges 1-4.
- Subtraction with cancellation: input1=0x44454000 (789), input2=0xC423C000 (-655) -> out=0x43060000 (134). Swapped order (input1=0xC423C000, input2=0x44454000) -> identical 0x43060000.
- Same-sign carry-out: input1=0x440DF8F6 (567.89), input2=0x442C8000 (690) -> out=0x449D3C7B (1257.89), exponent incremented.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000 (ties to even).
  - 0x3F800000 + 0x33C00000 -> 0x3F800001.
- Specials:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x40400000 + 0xC0400000 -> 0x00000000.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
- Control:
  - strt held high for 3 cycles -> exactly one valid pulse per accepted start.
  - rst low at edge 2 of an operation -> busy=0, valid never pulses, out=0.
